// File: rtl/jt12_fir_pkg.sv
// Shared constants, state encoding and control payload for the jt12 decimation FIR sequencer.
package jt12_fir_pkg;

    localparam int unsigned STAGES      = 73;
    localparam int unsigned HALF_TAPS   = 37;
    localparam int unsigned CENTRE      = STAGES / 2;
    localparam int unsigned PAIR_OFFSET = STAGES - 1;
    localparam int unsigned COEF_WIDTH  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // MAC-side controls issued together with each tap
    typedef struct packed {
        logic [COEF_WIDTH-1:0] coef_addr;
        logic                  ch;
        logic                  pair_en;
        logic                  mac_en;
        logic                  mac_clr;
    } mac_ctrl_t;

endpackage

// File: rtl/jt12_fir_seq_if.sv
// Sequencer-to-datapath bus: buffer write/read addressing, MAC controls and status.
interface jt12_fir_seq_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                                   sample;
    logic                                   ram_we;
    logic [ADDR_WIDTH-1:0]                  wr_addr;
    logic [ADDR_WIDTH-1:0]                  rd_addr_a;
    logic [ADDR_WIDTH-1:0]                  rd_addr_b;
    logic [jt12_fir_pkg::COEF_WIDTH-1:0]    coef_addr;
    logic                                   ch;
    logic                                   pair_en;
    logic                                   mac_en;
    logic                                   mac_clr;
    logic                                   sample_out;
    logic                                   busy;
    logic                                   overrun;

    modport master (
        input  sample,
        output ram_we, wr_addr, rd_addr_a, rd_addr_b, coef_addr, ch,
               pair_en, mac_en, mac_clr, sample_out, busy, overrun
    );

    modport slave (
        output sample,
        input  ram_we, wr_addr, rd_addr_a, rd_addr_b, coef_addr, ch,
               pair_en, mac_en, mac_clr, sample_out, busy, overrun
    );
endinterface

// File: rtl/jt12_fir_addr.sv
// Modular tap-pair read addresses: newest sample minus k, and oldest sample plus k.
module jt12_fir_addr #(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [5:0]            k,
    output logic [ADDR_WIDTH-1:0] rd_addr_a_c,
    output logic [ADDR_WIDTH-1:0] rd_addr_b_c
);
    import jt12_fir_pkg::*;

    logic [ADDR_WIDTH-1:0] base;

    // wr_ptr already points past the newest sample; wrap is the natural modulo of the width
    assign base        = wr_ptr - ADDR_WIDTH'(1);
    assign rd_addr_a_c = base - ADDR_WIDTH'(k);
    assign rd_addr_b_c = base - ADDR_WIDTH'(PAIR_OFFSET) + ADDR_WIDTH'(k);

endmodule

// File: rtl/jt12_fir_seq.sv
// Control sequencer for the shared symmetric 73-tap FIR datapath: write, two tap walks, flush, done.
module jt12_fir_seq #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned HALF_TAPS  = 37,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    jt12_fir_seq_if.master bus
);
    import jt12_fir_pkg::*;

    localparam int unsigned FW     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [5:0]  K_LAST = 6'(HALF_TAPS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [5:0]            k;
    logic                  ch_r;
    logic [FW-1:0]         flush_cnt;

    logic [5:0]            k_nxt;
    logic                  ch_nxt;
    logic [ADDR_WIDTH-1:0] rd_a_c;
    logic [ADDR_WIDTH-1:0] rd_b_c;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_a;
    logic [ADDR_WIDTH-1:0] rd_b;
    mac_ctrl_t             ctrl;
    logic                  sample_out;
    logic                  busy;
    logic                  overrun;

    // Tap to be presented after the coming edge; restarts at 0 on write and on channel switch
    always_comb begin
        k_nxt  = 6'd0;
        ch_nxt = ch_r;
        if (state == ST_RUN) begin
            if (k == K_LAST) begin
                ch_nxt = 1'b1;
            end else begin
                k_nxt = k + 6'd1;
            end
        end
    end

    jt12_fir_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .wr_ptr      (wr_ptr),
        .k           (k_nxt),
        .rd_addr_a_c (rd_a_c),
        .rd_addr_b_c (rd_b_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            k          <= '0;
            ch_r       <= 1'b0;
            flush_cnt  <= '0;
            ram_we     <= 1'b0;
            wr_addr    <= '0;
            rd_a       <= '0;
            rd_b       <= '0;
            ctrl       <= '0;
            sample_out <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            wr_addr    <= '0;
            rd_a       <= '0;
            rd_b       <= '0;
            ctrl       <= '0;
            sample_out <= 1'b0;
            overrun    <= bus.sample && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (bus.sample) begin
                        state   <= ST_WRITE;
                        ram_we  <= 1'b1;
                        wr_addr <= wr_ptr;
                        wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                        k       <= '0;
                        ch_r    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_WRITE, ST_RUN: begin
                    if (state == ST_RUN && k == K_LAST && ch_r) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else begin
                        state <= ST_RUN;
                        k     <= k_nxt;
                        ch_r  <= ch_nxt;
                        rd_a  <= rd_a_c;
                        rd_b  <= rd_b_c;
                        ctrl  <= '{coef_addr: k_nxt,
                                   ch:        ch_nxt,
                                   pair_en:   (k_nxt != K_LAST),
                                   mac_en:    1'b1,
                                   mac_clr:   (k_nxt == 6'd0)};
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FW'(MAC_LAT - 1)) begin
                        state      <= ST_DONE;
                        sample_out <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_we     = ram_we;
    assign bus.wr_addr    = wr_addr;
    assign bus.rd_addr_a  = rd_a;
    assign bus.rd_addr_b  = rd_b;
    assign bus.coef_addr  = ctrl.coef_addr;
    assign bus.ch         = ctrl.ch;
    assign bus.pair_en    = ctrl.pair_en;
    assign bus.mac_en     = ctrl.mac_en;
    assign bus.mac_clr    = ctrl.mac_clr;
    assign bus.sample_out = sample_out;
    assign bus.busy       = busy;
    assign bus.overrun    = overrun;

endmodule

// File: doc/jt12_fir_seq.md
# jt12_fir_seq

Control sequencer for the time-multiplexed, symmetric 73-tap decimation FIR behind the jt12 audio output. On each `sample` strobe it writes the new stereo sample into the circular sample buffer. It then walks the 37 coefficient indices twice, left channel then right. It drives read addresses, coefficient address and MAC controls so that one shared pre-adder/multiplier/accumulator datapath serves both channels. It owns no arithmetic and no storage beyond pointers, counters and state.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: sample-buffer address width; buffer depth is 2^ADDR_WIDTH, which must be ≥ 73.
- `HALF_TAPS`, 37: coefficient count. Index 0..35 are symmetric pairs; index 36 is the centre tap.
- `MAC_LAT`, 2: datapath latency in clk cycles from address issue to accumulator update.

Ports (name, direction, width, meaning):
- `clk`, in, 1: jt12 `clk_out`; the single clock for the block.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `sample`, in, 1: one-cycle strobe; new left/right input is valid.
- `ram_we`, out, 1: sample-buffer write enable; both channels are written together.
- `wr_addr`, out, ADDR_WIDTH: sample-buffer write address.
- `rd_addr_a`, out, ADDR_WIDTH: newer-side read address of the tap pair.
- `rd_addr_b`, out, ADDR_WIDTH: older-side read address of the tap pair.
- `coef_addr`, out, 6: coefficient ROM index, 0..HALF_TAPS-1.
- `ch`, out, 1: channel being computed; 0 = left, 1 = right.
- `pair_en`, out, 1: 1 = pre-add a+b; 0 = use a alone (centre tap).
- `mac_en`, out, 1: accumulate this cycle.
- `mac_clr`, out, 1: load the product instead of adding, on the first tap of a channel.
- `sample_out`, out, 1: one-cycle strobe; both accumulators hold final results.
- `busy`, out, 1: high in every state except IDLE.
- `overrun`, out, 1: one-cycle pulse when a `sample` strobe is dropped.

## Operation
- State machine: IDLE, WRITE, RUN, FLUSH, DONE.
- Internal registers: `wr_ptr` (ADDR_WIDTH), `k` (6 bits), `ch`, flush counter.
- IDLE → WRITE on `sample`.
- WRITE, 1 cycle:
  - `ram_we`=1, `wr_addr`=`wr_ptr`.
  - `wr_ptr` increments modulo 2^ADDR_WIDTH.
  - `k`=0, `ch`=0.
  - Next state is RUN.
- RUN, one tap per cycle:
  - `base` = `wr_ptr`−1, i.e. the newest sample.
  - `rd_addr_a` = base−k; `rd_addr_b` = base−72+k; both wrap modulo 2^ADDR_WIDTH.
  - `coef_addr`=k, `mac_en`=1, `mac_clr`=(k==0), `pair_en`=(k≠HALF_TAPS−1).
  - On k==HALF_TAPS−1: if `ch`==0, set k=0 and ch=1; otherwise go to FLUSH.
- FLUSH, MAC_LAT cycles: all MAC controls are 0. Then go to DONE.
- DONE, 1 cycle: `sample_out`=1. Then go to IDLE.
- A `sample` strobe in any state other than IDLE is dropped:
  - `overrun` pulses on the following cycle.
  - `wr_ptr` is unchanged.
  - The sequence in progress is unaffected.
- A `sample` strobe in DONE is also dropped. IDLE is the only accepting state.
- In the centre-tap cycle `rd_addr_b` still carries the computed value (base−36 for both); the datapath ignores it.
- Outputs are registered. Address and control outputs are 0 in every state other than WRITE and RUN.

## Timing
- `sample` sampled high at edge t:
  - WRITE is active in cycle t+1.
  - Left taps k=0..36 occupy t+2..t+38.
  - Right taps occupy t+39..t+75.
  - FLUSH occupies t+76..t+75+MAC_LAT.
  - `sample_out` is high in cycle t+76+MAC_LAT.
- Busy period is 2·HALF_TAPS+MAC_LAT+2 cycles (78 with defaults). Minimum sample spacing is 79 cycles.
- Reset (asserted at any time, including mid-RUN):
  - State returns to IDLE; `wr_ptr`=0, `k`=0, `ch`=0.
  - All outputs are 0.
  - The interrupted result is lost and no `sample_out` is issued.
- Deassertion of reset is synchronised externally. The first `sample` is accepted on the first clk edge with `rst_n`=1.

## Structure
- Shared package `jt12_fir_pkg`:
  - State encoding.
  - STAGES=73 and HALF_TAPS=37.
  - CENTRE = STAGES/2.
  - The pair-offset constant 72 (STAGES−1).
- One sub-module, `jt12_fir_addr`: combinational modular computation of `rd_addr_a`/`rd_addr_b` from `wr_ptr` and `k`, registered in the parent.

## Test plan
- Reset, then `sample` at cycle 0:
  - `ram_we`=1 with `wr_addr`=0 at cycle 1.
  - k=0 at cycle 2: `rd_addr_a`=0, `rd_addr_b`=56, `mac_clr`=1.
  - k=36 at cycle 38: `rd_addr_a`=92, `pair_en`=0.
  - `sample_out` at cycle 78.
- Ch switch: at cycle 39, `ch`=1, `coef_addr`=0, `mac_clr`=1, and addresses repeat the cycle-2 values.
- Wrap: drive 127 spaced samples, then one more.
  - That write uses `wr_addr`=127; `wr_ptr` wraps to 0.
  - k=0 gives `rd_addr_a`=127, `rd_addr_b`=55.
- Overrun: `sample` at 0 and at 40.
  - `overrun`=1 at cycle 41.
  - `sample_out` still at 78.
  - The next accepted sample writes `wr_addr`=1.
- Reset mid-RUN: assert `rst_n`=0 at cycle 20.
  - All outputs are 0 asynchronously.
  - No `sample_out`.
  - The next `sample` writes `wr_addr`=0.
- Back-to-back: `sample` at 0 and at 79; both are accepted, with `sample_out` at 78 and at 157.
